audio_mixer_pwm: RTL

Parametrised successor to the fixed three-channel mixer-plus-PWM output stage.
- Mixes NUM_CH unsigned channel samples using per-channel 4-bit volume and mute.
- Accumulates time-multiplexed, one channel per clock, with a single multiplier.
- Saturates the sum to the PWM range and drives a runtime-programmable-period PWM DAC.
- Sits between the channel generators and the PMOD audio pin.

---
 rtl/audio_mixer_pwm_if.sv | 35 +++
 rtl/audio_mixer_pwm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer_pwm_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_mixer_pwm_if
// Description : Channel-sample / volume / mute / PWM-top inputs and the PWM
//               status outputs of audio_mixer_pwm, bundled as one interface.
//               master = channel-generator side, slave = the mixer.
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_mixer_pwm_if #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 9,
    parameter int VOL_W  = 4,
    parameter int TOP_W  = 9
) ();
    logic [NUM_CH*IN_W-1:0]  i_ch_sample;
    logic [NUM_CH*VOL_W-1:0] i_ch_vol;
    logic [NUM_CH-1:0]       i_ch_mute;
    logic [TOP_W-1:0]        i_top;
    logic                    o_pwm;
    logic                    o_cycle_end;
    logic [TOP_W:0]          o_compare;
    logic                    o_clip;
    logic                    o_overrun;

    modport master (
        output i_ch_sample, i_ch_vol, i_ch_mute, i_top,
        input  o_pwm, o_cycle_end, o_compare, o_clip, o_overrun
    );

    modport slave (
        input  i_ch_sample, i_ch_vol, i_ch_mute, i_top,
        output o_pwm, o_cycle_end, o_compare, o_clip, o_overrun
    );
endinterface
`default_nettype wire

// File: rtl/audio_mixer_pwm.sv
`default_nettype none
// ============================================================================
// Module      : audio_mixer_pwm
// Description : Time-multiplexed NUM_CH-channel mixer (one multiply per clock)
//               with per-channel volume/mute, saturation to the PWM range and
//               a programmable-period PWM DAC. Inputs sampled at one period
//               end are applied at the next period end.
//               Optional feature macro: MIXER_DITHER_EN (error-feedback
//               residue on the truncated mix).
// Revision    : 1.0 - initial release
// ============================================================================
module audio_mixer_pwm #(
    parameter int NUM_CH    = 4,
    parameter int IN_W      = 9,
    parameter int VOL_W     = 4,
    parameter int TOP_W     = 9,
    parameter int TOP_RESET = 255
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst_n,
    audio_mixer_pwm_if.slave  bus
);
    localparam int C_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int C_ACC_W  = IN_W + VOL_W + $clog2(NUM_CH) + 1;
    localparam int C_PROD_W = IN_W + VOL_W + 1;
    localparam int C_MIX_W  = C_ACC_W - VOL_W;
    localparam int C_CMP_W  = (C_MIX_W > TOP_W + 1) ? C_MIX_W : TOP_W + 1;

    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(NUM_CH - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_ONE  = C_IDX_W'(1);
    localparam logic [TOP_W-1:0]   C_CNT_ONE  = TOP_W'(1);
    localparam logic [TOP_W:0]     C_LIM_ONE  = (TOP_W + 1)'(1);
    localparam logic [VOL_W:0]     C_VOL_ONE  = (VOL_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_CLAMP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [TOP_W-1:0]   r_cnt;
    logic [TOP_W-1:0]   r_top_q;
    logic               r_pwm;
    logic [TOP_W:0]     r_compare;
    logic [TOP_W:0]     r_pending;
    logic               r_pending_valid;
    logic               r_clip;
    logic               r_overrun;
    logic [IN_W-1:0]    r_smp  [NUM_CH];
    logic [VOL_W-1:0]   r_vol  [NUM_CH];
    logic [NUM_CH-1:0]  r_mute;
    logic [C_IDX_W-1:0] r_idx;
    logic [C_ACC_W-1:0] r_acc;

    logic                w_cycle_end;
    logic                w_busy;
    logic [VOL_W:0]      w_vol_p1;
    logic [C_PROD_W-1:0] w_prod;
    logic [C_PROD_W-1:0] w_term;
    logic [C_ACC_W-1:0]  w_acc_add;
    logic [C_MIX_W-1:0]  w_mix;
    logic [C_CMP_W-1:0]  w_mix_x;
    logic [TOP_W:0]      w_lim;
    logic [C_CMP_W-1:0]  w_lim_x;
    logic                w_sat;
    logic [TOP_W:0]      w_result;

    assign w_cycle_end = (r_cnt == r_top_q);
    assign w_busy      = (r_state != S_IDLE);

    // Single shared multiplier: the channel selected by r_idx, gain = vol+1.
    assign w_vol_p1  = {1'b0, r_vol[r_idx]} + C_VOL_ONE;
    assign w_prod    = {{(VOL_W + 1){1'b0}}, r_smp[r_idx]} * {{IN_W{1'b0}}, w_vol_p1};
    assign w_term    = r_mute[r_idx] ? '0 : w_prod;
    assign w_acc_add = r_acc + {{(C_ACC_W - C_PROD_W){1'b0}}, w_term};

`ifdef MIXER_DITHER_EN
    // Fraction lost by the shift is carried into the next mix.
    logic [VOL_W-1:0]   r_residue;
    logic [C_ACC_W-1:0] w_sum;
    assign w_sum = r_acc + {{(C_ACC_W - VOL_W){1'b0}}, r_residue};
    assign w_mix = w_sum[C_ACC_W-1:VOL_W];
`else
    assign w_mix = r_acc[C_ACC_W-1:VOL_W];
`endif

    // Full-scale compare is top+1 (output permanently high).
    assign w_mix_x  = C_CMP_W'(w_mix);
    assign w_lim    = {1'b0, r_top_q} + C_LIM_ONE;
    assign w_lim_x  = C_CMP_W'(w_lim);
    assign w_sat    = (w_mix_x > w_lim_x);
    assign w_result = w_sat ? w_lim : w_mix_x[TOP_W:0];

    // PWM counter, period register and registered comparator output.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_top_q <= TOP_W'(TOP_RESET);
            r_pwm   <= 1'b0;
        end else begin
            r_pwm <= ({1'b0, r_cnt} < r_compare);
            if (w_cycle_end) begin
                r_cnt   <= '0;
                r_top_q <= bus.i_top;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: a period end always (re)starts a mix from a fresh snapshot.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cycle_end) w_state_next = S_ACCUM;
            end
            S_ACCUM: begin
                if (w_cycle_end)              w_state_next = S_ACCUM;
                else if (r_idx == C_IDX_LAST) w_state_next = S_CLAMP;
            end
            S_CLAMP: begin
                w_state_next = w_cycle_end ? S_ACCUM : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Mix datapath: snapshot, accumulate, clamp, and apply at period end.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_smp[k] <= '0;
                r_vol[k] <= '0;
            end
            r_mute          <= '0;
            r_acc           <= '0;
            r_idx           <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_compare       <= '0;
            r_clip          <= 1'b0;
            r_overrun       <= 1'b0;
`ifdef MIXER_DITHER_EN
            r_residue       <= '0;
`endif
        end else begin
            r_clip    <= 1'b0;
            r_overrun <= w_cycle_end && w_busy;
            if (w_cycle_end) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    r_smp[k] <= bus.i_ch_sample[k*IN_W +: IN_W];
                    r_vol[k] <= bus.i_ch_vol[k*VOL_W +: VOL_W];
                end
                r_mute <= bus.i_ch_mute;
                r_acc  <= '0;
                r_idx  <= '0;
                // An unfinished mix is dropped; only completed results apply.
                if (r_pending_valid) begin
                    r_compare       <= r_pending;
                    r_pending_valid <= 1'b0;
                end
            end else if (r_state == S_ACCUM) begin
                r_acc <= w_acc_add;
                r_idx <= r_idx + C_IDX_ONE;
            end else if (r_state == S_CLAMP) begin
                r_pending       <= w_result;
                r_pending_valid <= 1'b1;
                r_clip          <= w_sat;
`ifdef MIXER_DITHER_EN
                r_residue       <= w_sum[VOL_W-1:0];
`endif
            end
        end
    end

    assign bus.o_pwm       = r_pwm;
    assign bus.o_cycle_end = w_cycle_end;
    assign bus.o_compare   = r_compare;
    assign bus.o_clip      = r_clip;
    assign bus.o_overrun   = r_overrun;
endmodule
`default_nettype wire
